// File: rtl/wfunc_apb_loader.sv
// APB initiator that soft-resets window_func, programs its mode, streams one
// coefficient table into it from AXI-Stream, arms it, and polls until it leaves IDLE.
module wfunc_apb_loader #(
    parameter int FFT_SIZE = 8192,
    parameter int APB_AW   = $clog2(FFT_SIZE-1)+3,
    parameter int POLL_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              one_pack,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    input  logic              coef_tvalid,
    output logic              coef_tready,
    input  logic [31:0]       coef_tdata,
    input  logic              coef_tlast,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_AW-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata
);
    localparam int CW = $clog2(FFT_SIZE);
    localparam int PW = $clog2(POLL_MAX+1);
    localparam logic [APB_AW-1:0] CTRL1_A = APB_AW'(FFT_SIZE*4);
    localparam logic [APB_AW-1:0] STAT_A  = APB_AW'((FFT_SIZE+1)*4);
    localparam logic [CW-1:0]     LAST_N  = CW'(FFT_SIZE-1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_CFG, S_LOAD, S_ARM, S_POLL, S_FIN} state_t;

    state_t        state;
    logic [31:0]   shadow;
    logic          op;
    logic          fin;
    logic [CW-1:0] cnt;
    logic [PW-1:0] polls;

    logic unused_prdata;
    assign unused_prdata = ^{prdata[31:10], prdata[7:0]};

    // Every APB phase change happens in this block; a state's last ACCESS edge
    // already launches the next state's SETUP so transfers can run back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shadow      <= '0;
            op          <= 1'b0;
            fin         <= 1'b0;
            cnt         <= '0;
            polls       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            coef_tready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 2'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_RST;
                    op      <= one_pack;
                    err     <= 2'd0;
                    busy    <= 1'b1;
                    psel    <= 1'b1;
                    penable <= 1'b0;
                    pwrite  <= 1'b1;
                    paddr   <= CTRL1_A;
                    pwdata  <= shadow ^ 32'h1;
                    shadow  <= shadow ^ 32'h1;
                end
                S_RST: begin
                    if (!penable) penable <= 1'b1;
                    else begin
                        state   <= S_CFG;
                        penable <= 1'b0;
                        paddr   <= STAT_A;
                        pwdata  <= {31'b0, op};
                    end
                end
                S_CFG: begin
                    if (!penable) penable <= 1'b1;
                    else begin
                        state       <= S_LOAD;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        coef_tready <= 1'b1;
                        cnt         <= '0;
                        fin         <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (coef_tready && coef_tvalid) begin
                        coef_tready <= 1'b0;
                        psel        <= 1'b1;
                        penable     <= 1'b0;
                        paddr       <= APB_AW'({cnt, 2'b00});
                        pwdata      <= coef_tdata;
                        fin         <= coef_tlast || (cnt == LAST_N);
                        if (coef_tlast && cnt != LAST_N) err <= 2'd1;
                        if (!coef_tlast && cnt == LAST_N) err <= 2'd2;
                        if (!coef_tlast && cnt != LAST_N) cnt <= cnt + 1'b1;
                    end else if (psel && !penable) begin
                        penable     <= 1'b1;
                        coef_tready <= !fin;
                    end else if (penable && fin) begin
                        penable <= 1'b0;
                        if (err == 2'd0) begin
                            state  <= S_ARM;
                            paddr  <= CTRL1_A;
                            pwdata <= shadow ^ 32'h100;
                            shadow <= shadow ^ 32'h100;
                        end else begin
                            state <= S_FIN;
                            psel  <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (!penable) penable <= 1'b1;
                    else begin
                        state   <= S_POLL;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        paddr   <= STAT_A;
                        polls   <= '0;
                    end
                end
                S_POLL: begin
                    if (!penable) penable <= 1'b1;
                    else begin
                        penable <= 1'b0;
                        // 01 = WAIT, 10 = BUSY: the windowing FSM has left IDLE.
                        if (prdata[9:8] == 2'b01 || prdata[9:8] == 2'b10 ||
                            polls == PW'(POLL_MAX-1)) begin
                            if (!(prdata[9:8] == 2'b01 || prdata[9:8] == 2'b10)) err <= 2'd3;
                            state <= S_FIN;
                            psel  <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            polls <= polls + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wfunc_apb_loader.sv
// Bench for wfunc_apb_loader: window_func slave model, expected-transfer queue
// built from the load rules, and a per-cycle APB compare process.
module tb_wfunc_apb_loader;
    localparam int N  = 8;
    localparam int PM = 4;
    localparam int AW = $clog2(N-1)+3;
    localparam logic [AW-1:0] CTRL1 = AW'(N*4);
    localparam logic [AW-1:0] STAT  = AW'((N+1)*4);

    logic clk = 0, rst = 1, start = 0, one_pack = 0;
    logic busy, done, coef_tready, psel, penable, pwrite;
    logic [1:0] err;
    logic coef_tvalid = 0, coef_tlast = 0;
    logic [31:0] coef_tdata = 0, pwdata, prdata;
    logic [AW-1:0] paddr;

    wfunc_apb_loader #(.FFT_SIZE(N), .APB_AW(AW), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst), .start(start), .one_pack(one_pack),
        .busy(busy), .done(done), .err(err),
        .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
        .coef_tdata(coef_tdata), .coef_tlast(coef_tlast),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct { logic [AW-1:0] a; logic w; logic [31:0] d; } xfer_t;
    xfer_t expq[$];
    logic [31:0] ctrl_log[$];
    logic [31:0] ctrl_m = 0;

    // window_func slave model: toggle-detected commands, 2-bit FSM state in STAT[9:8]
    logic [31:0] s_ctrl = 0, s_mem[N];
    logic [1:0]  s_st = 0;
    logic        s_stall = 0;
    int n_soft = 0, n_arm = 0, n_stat_rd = 0, n_coef = 0, n_done = 0;
    assign prdata = (paddr == STAT) ? {22'b0, (s_stall ? 2'b00 : s_st), 8'b0} : 32'h0;

    int cyc = 0, t0 = 0, done_cyc = -1, first_rdy = -1;
    always @(posedge clk) cyc <= cyc + 1;

    bit mon_en = 0, prev_setup = 0, pw_q = 0;
    logic [AW-1:0] pa_q = 0;
    logic [31:0]   pd_q = 0;
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            chk("tready_during_setup", {31'b0, coef_tready && psel && !penable}, 0);
            chk("busy_during_xfer", {31'b0, psel && !busy}, 0);
            if (penable) begin
                chk("access_follows_setup",
                    {31'b0, prev_setup && psel && paddr == pa_q && pwdata == pd_q && pwrite == pw_q}, 1);
                if (expq.size() == 0) chk("unexpected_xfer", {{(32-AW){1'b0}}, paddr}, 32'hFFFF_FFFF);
                else begin
                    xfer_t x;
                    x = expq.pop_front();
                    chk("xfer_addr", {{(32-AW){1'b0}}, paddr}, {{(32-AW){1'b0}}, x.a});
                    chk("xfer_write", {31'b0, pwrite}, {31'b0, x.w});
                    if (x.w) chk("xfer_data", pwdata, x.d);
                end
                if (pwrite && paddr == CTRL1) begin
                    if ((pwdata ^ s_ctrl) & 32'h1)   begin s_st = 2'b00; n_soft++; end
                    if ((pwdata ^ s_ctrl) & 32'h100) begin s_st = 2'b01; n_arm++;  end
                    s_ctrl = pwdata;
                    ctrl_log.push_back(pwdata);
                end else if (pwrite && paddr < AW'(N*4)) begin
                    s_mem[paddr >> 2] = pwdata;
                    n_coef++;
                end else if (!pwrite && paddr == STAT) n_stat_rd++;
            end
            prev_setup = psel && !penable;
            pa_q = paddr; pd_q = pwdata; pw_q = pwrite;
            if (done) begin n_done++; done_cyc = cyc - t0; end
            if (coef_tready && first_rdy < 0) first_rdy = cyc - t0;
        end
    end

    logic [31:0] stim[N];

    // Builds the expected transfer list from the load rules, drives one load, checks err.
    task automatic run_load(input logic op, input int tl_pos, input int gap, input bit stall);
        int t, e_err, nd0, idx;
        bit hs, got;
        s_stall = stall;
        ctrl_m ^= 32'h1;
        expq.push_back('{CTRL1, 1'b1, ctrl_m});
        expq.push_back('{STAT, 1'b1, {31'b0, op}});
        t = (tl_pos >= 0 && tl_pos < N) ? tl_pos : N-1;
        e_err = (tl_pos < 0 || tl_pos >= N) ? 2 : (tl_pos < N-1) ? 1 : 0;
        for (int i = 0; i <= t; i++) expq.push_back('{AW'(i*4), 1'b1, stim[i]});
        if (e_err == 0) begin
            ctrl_m ^= 32'h100;
            expq.push_back('{CTRL1, 1'b1, ctrl_m});
            for (int i = 0; i < (stall ? PM : 1); i++) expq.push_back('{STAT, 1'b0, 32'h0});
            e_err = stall ? 3 : 0;
        end
        @(negedge clk);
        start = 1; one_pack = op; t0 = cyc; first_rdy = -1; done_cyc = -1;
        nd0 = n_done; idx = 0; hs = 0; got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            start = 0;
            if (idx < N) begin
                if (!coef_tvalid || hs) coef_tvalid = ($urandom_range(99) >= gap);
                coef_tdata = stim[idx];
                coef_tlast = (idx == tl_pos);
            end else coef_tvalid = 0;
            hs = coef_tvalid && coef_tready;
            if (hs) idx++;
            got = (n_done > nd0);
        end
        coef_tvalid = 0; coef_tlast = 0;
        if (!got) chk("done_timeout", 0, 1);
        chk("err", {30'b0, err}, e_err);
        chk("expected_xfers_drained", expq.size(), 0);
        expq.delete();
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 0);
        chk("busy_after_done", {31'b0, busy}, 0);
    endtask

    initial begin
        int soft0, arm0, rd0, cf0;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_psel", {31'b0, psel}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {30'b0, err}, 0);
        chk("rst_tready", {31'b0, coef_tready}, 0);
        rst = 0; mon_en = 1;
        @(negedge clk);

        // 1: continuous stream, tlast on beat 7
        for (int i = 0; i < N; i++) stim[i] = 32'h0001_0000 + i;
        run_load(1, 7, 0, 0);
        chk("t1_done_cycle", done_cyc, 26);
        chk("t1_first_tready", first_rdy, 5);
        chk("t1_ctrl_rst", ctrl_log[0], 32'h1);
        chk("t1_ctrl_arm", ctrl_log[1], 32'h101);
        chk("t1_mem7", s_mem[7], 32'h0001_0007);
        chk("t1_slave_wait", {30'b0, s_st}, 2'b01);

        // 2: back-to-back load proves toggle commands
        for (int i = 0; i < N; i++) stim[i] = 32'h0002_0000 + i;
        run_load(0, 7, 0, 0);
        chk("t2_ctrl_rst", ctrl_log[2], 32'h100);
        chk("t2_ctrl_arm", ctrl_log[3], 32'h0);
        chk("t2_soft_count", n_soft, 2);
        chk("t2_arm_count", n_arm, 2);

        // 3: ~50% valid gaps, random data
        for (int i = 0; i < N; i++) stim[i] = $urandom;
        run_load(1, 7, 50, 0);
        for (int i = 0; i < N; i++) chk("t3_mem", s_mem[i], stim[i]);

        // 4: early tlast on beat 3
        cf0 = n_coef; arm0 = n_arm;
        for (int i = 0; i < N; i++) stim[i] = 32'hA000_0000 + i;
        run_load(1, 3, 0, 0);
        chk("t4_coef_writes", n_coef - cf0, 4);
        chk("t4_no_arm", n_arm - arm0, 0);
        chk("t4_slave_idle", {30'b0, s_st}, 0);

        // 5: tlast missing
        cf0 = n_coef; arm0 = n_arm;
        run_load(0, -1, 0, 0);
        chk("t5_coef_writes", n_coef - cf0, 8);
        chk("t5_no_arm", n_arm - arm0, 0);

        // 6: slave never leaves IDLE -> poll timeout
        rd0 = n_stat_rd;
        run_load(1, 7, 0, 1);
        chk("t6_stat_reads", n_stat_rd - rd0, 4);
        s_stall = 0;

        // 6b: reset in the middle of LOAD
        mon_en = 0;
        @(negedge clk);
        start = 1; one_pack = 1; coef_tvalid = 1; coef_tdata = 32'h5555_AAAA; coef_tlast = 0;
        @(negedge clk);
        start = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            seen = coef_tready;
        end
        chk("t6_reached_load", {31'b0, seen}, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("t6_rst_psel", {31'b0, psel}, 0);
        chk("t6_rst_penable", {31'b0, penable}, 0);
        chk("t6_rst_pwrite", {31'b0, pwrite}, 0);
        chk("t6_rst_paddr", {{(32-AW){1'b0}}, paddr}, 0);
        chk("t6_rst_pwdata", pwdata, 0);
        chk("t6_rst_tready", {31'b0, coef_tready}, 0);
        chk("t6_rst_busy", {31'b0, busy}, 0);
        chk("t6_rst_done", {31'b0, done}, 0);
        chk("t6_rst_err", {30'b0, err}, 0);
        rst = 0; coef_tvalid = 0;
        s_ctrl = 0; s_st = 0; ctrl_m = 0; prev_setup = 0; expq.delete(); ctrl_log.delete();
        mon_en = 1;

        // recovery: fresh load after reset behaves like test 1
        soft0 = n_soft;
        for (int i = 0; i < N; i++) stim[i] = 32'h0001_0000 + i;
        run_load(1, 7, 0, 0);
        chk("rec_done_cycle", done_cyc, 26);
        chk("rec_ctrl_rst", ctrl_log[0], 32'h1);
        chk("rec_soft", n_soft - soft0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
